// File: rtl/quadrature_decoder_counter_if.sv
// -----------------------------------------------------------------------------
// quadrature_decoder_counter_if
//
// Purpose: groups the encoder pins, the control strobes and the position
//          outputs of quadrature_decoder_counter into one bundle.
//
// Signals:
//   enc_a, enc_b  phase A / phase B from the encoder pins (asynchronous)
//   en            count enable
//   clear         synchronous clear of count and err
//   count [N]     position, modulo 2^N
//   dir           direction of the last counted step (1 = up)
//   step          one-cycle pulse per counted step
//   wrap          one-cycle pulse when count wraps
//   err           sticky illegal-transition flag
//
// Modports:
//   master  side that drives pins/controls and observes the position
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface quadrature_decoder_counter_if #(
   parameter int N = 4
);
   logic         enc_a;
   logic         enc_b;
   logic         en;
   logic         clear;
   logic [N-1:0] count;
   logic         dir;
   logic         step;
   logic         wrap;
   logic         err;

   modport master (
      output enc_a, enc_b, en, clear,
      input  count, dir, step, wrap, err
   );

   modport slave (
      input  enc_a, enc_b, en, clear,
      output count, dir, step, wrap, err
   );
endinterface

// File: rtl/quadrature_decoder_counter.sv
// -----------------------------------------------------------------------------
// quadrature_decoder_counter
//
// Purpose: synchronizes a two-phase quadrature pair, decodes each phase
//          transition into an up step, a down step or an illegal jump, and
//          accumulates valid steps in an N-bit modulo position counter.
//
// Parameters:
//   N            width of the position counter (>= 2)
//   SYNC_STAGES  flip-flop stages per input synchronizer (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    quadrature_decoder_counter_if.slave (pins, en/clear, outputs)
//
// All outputs are registered. A pin change stable before edge k shows up on
// the outputs after edge k+SYNC_STAGES.
// -----------------------------------------------------------------------------
module quadrature_decoder_counter #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   quadrature_decoder_counter_if.slave   bus
);

   // Synchronizer chains. fill tracks how far real pin samples have travelled
   // down the chain since reset, so priming waits for a genuine pin value
   // instead of the reset zeros (otherwise pins held at 11 would look like an
   // illegal 00->11 jump).
   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic [SYNC_STAGES-1:0] fill;

   logic [1:0]   s;          // synchronized {a,b}
   logic [1:0]   p;          // last evaluated {a,b}
   logic         primed;
   logic         s_valid;

   logic [N-1:0] count_q;
   logic         dir_q;
   logic         step_q;
   logic         wrap_q;
   logic         err_q;

   logic [1:0]   delta;
   logic         up;
   logic         down;
   logic         illegal;

   // Position of a phase pair on the cycle 00->01->11->10: Gray to binary.
   function automatic logic [1:0] phase(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   assign s       = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
   assign s_valid = fill[SYNC_STAGES-1];

   // Distance travelled around the 4-state cycle: +1 is up, -1 (3) is down,
   // 2 means both bits flipped and the direction is unknowable.
   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves one unassigned and no latch is inferred.
   always_comb begin
      delta   = phase(s) - phase(p);
      up      = 1'b0;
      down    = 1'b0;
      illegal = 1'b0;
      if (primed) begin
         case (delta)
            2'd1:    up      = 1'b1;
            2'd3:    down    = 1'b1;
            2'd2:    illegal = 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a  <= '0;
         sync_b  <= '0;
         fill    <= '0;
         p       <= 2'b00;
         primed  <= 1'b0;
         count_q <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
         sync_b <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
         fill   <= {fill[SYNC_STAGES-2:0], 1'b1};

         step_q <= 1'b0;
         wrap_q <= 1'b0;

         // p follows s on every cycle once there is a real sample, whatever
         // en, clear or err are doing.
         if (s_valid) begin
            p      <= s;
            primed <= 1'b1;
         end

         if (bus.clear) begin
            // A same-cycle step or error is dropped, not deferred.
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            if (illegal) begin
               err_q <= 1'b1;
            end
            if (bus.en && (up || down)) begin
               count_q <= up ? count_q + N'(1) : count_q - N'(1);
               dir_q   <= up;
               step_q  <= 1'b1;
               wrap_q  <= up ? (count_q == '1) : (count_q == '0);
            end
         end
      end
   end

   assign bus.count = count_q;
   assign bus.dir   = dir_q;
   assign bus.step  = step_q;
   assign bus.wrap  = wrap_q;
   assign bus.err   = err_q;

endmodule
